// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 7-segment scan controller with dead time,
// frame-atomic display updates and leading-zero blanking
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] shadow, display;
    logic                    pending;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   sup;
    logic                    acc;
    logic [3:0]              nib;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    fd_n;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        frame_end = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
                BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_n = SHOW;
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        if (idx == IDX_LAST) begin
                            idx_n     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        acc = 1'b0;
        sup = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc    = acc | (display[4*k +: 4] != 4'd0);
            sup[k] = lz_blank && !acc && (k != 0);
        end
    end

    always_comb begin
        nib  = 4'd0;
        an_n = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx_n) begin
                nib = display[4*k +: 4];
                if (state_n == SHOW && !sup[k]) an_n[k] = 1'b0;
            end
        end
    end

    always_comb begin
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
        seg_n = (&an_n) ? 7'b1111111 : glyph;
        fd_n  = (state_n == SHOW) && (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            an         <= '1;
            seg        <= 7'b1111111;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            an         <= an_n;
            seg        <= seg_n;
            frame_done <= fd_n;
            if (load) shadow <= value;
            // A load landing on the boundary cycle bypasses the shadow straight to the display.
            if (frame_end) begin
                if (load) display <= value;
                else if (pending) display <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .load(load),
        .lz_blank(lz_blank), .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_tab(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected {an, seg, frame_done} for cycle c of slot d while showing v.
    function automatic logic [11:0] frame_exp(input logic [15:0] v, input logic lz,
                                              input int d, input int c);
        logic [3:0] nib;
        logic       lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        nib   = v[4*d +: 4];
        lit   = (c >= 2) && !(lz && d != 0 && (v >> (4*d)) == 16'h0);
        e_an  = lit ? ~(4'b0001 << d) : 4'b1111;
        e_seg = lit ? seg_tab(nib) : 7'b1111111;
        return {e_an, e_seg, (d == 3 && c == 7)};
    endfunction

    task automatic test_reset();
        logic [11:0] exp;
        rst = 1'b1; enable = 1'b0;
        step(); step();
        n_checks++;
        if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got an=%b seg=%b fd=%b, expected an=1111 seg=1111111 fd=0", an, seg, frame_done);
        end
        rst = 1'b0; enable = 1'b1;
        for (int t = 1; t < 8; t++) begin
            step();
            exp = frame_exp(16'h0, 1'b0, 0, t);
            n_checks++;
            if ({an, seg, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL reset_first_slot t=%0d: got %b, expected %b", t, {an, seg, frame_done}, exp);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [11:0] exp;
        value = 16'h12AF; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (frame_done) break;
            step();
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_wait_frame_done: got %b, expected 1 within 100 cycles", frame_done);
        end
        for (int t = 0; t < 64; t++) begin
            step();
            exp = frame_exp(16'h12AF, 1'b0, (t >> 3) & 3, t & 7);
            n_checks++;
            if ({an, seg, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL basic_scan t=%0d: got %b, expected %b", t, {an, seg, frame_done}, exp);
            end
        end
    endtask

    task automatic test_atomic_update();
        logic [11:0] exp;
        logic [15:0] shown;
        for (int t = 0; t < 96; t++) begin
            step();
            load = 1'b0;
            shown = (t < 32) ? 16'h12AF : (t < 64) ? 16'h3333 : 16'h4567;
            exp = frame_exp(shown, 1'b0, (t >> 3) & 3, t & 7);
            n_checks++;
            if ({an, seg, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL atomic_update t=%0d: got %b, expected %b", t, {an, seg, frame_done}, exp);
            end
            if (t == 11) begin value = 16'h3333; load = 1'b1; end
            if (t == 63) begin value = 16'h4567; load = 1'b1; end
        end
    endtask

    task automatic test_lz_blank();
        logic [11:0] exp;
        logic [15:0] vals [3];
        vals[0] = 16'h0005; vals[1] = 16'h0000; vals[2] = 16'h0105;
        lz_blank = 1'b1;
        for (int v = 0; v < 3; v++) begin
            value = vals[v]; load = 1'b1;
            step();
            load = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (frame_done) break;
                step();
            end
            n_checks++;
            if (frame_done !== 1'b1) begin
                n_fail++;
                $display("FAIL lz_wait_frame_done v=%h: got %b, expected 1", vals[v], frame_done);
            end
            for (int t = 0; t < 32; t++) begin
                step();
                exp = frame_exp(vals[v], 1'b1, t >> 3, t & 7);
                n_checks++;
                if ({an, seg, frame_done} !== exp) begin
                    n_fail++;
                    $display("FAIL lz_blank v=%h t=%0d: got %b, expected %b", vals[v], t, {an, seg, frame_done}, exp);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [11:0] exp;
        lz_blank = 1'b0;
        for (int t = 0; t <= 20; t++) begin
            step();
            exp = frame_exp(16'h0105, 1'b0, t >> 3, t & 7);
            n_checks++;
            if ({an, seg, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL enable_pre_drop t=%0d: got %b, expected %b", t, {an, seg, frame_done}, exp);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
                n_fail++;
                $display("FAIL enable_idle i=%0d: got an=%b seg=%b fd=%b, expected dark", i, an, seg, frame_done);
            end
        end
        enable = 1'b1;
        for (int t = 0; t < 32; t++) begin
            step();
            exp = frame_exp(16'h0105, 1'b0, t >> 3, t & 7);
            n_checks++;
            if ({an, seg, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL enable_resume t=%0d: got %b, expected %b", t, {an, seg, frame_done}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [11:0] exp;
        value = 16'h9876; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_op: got an=%b seg=%b fd=%b, expected dark", an, seg, frame_done);
        end
        rst = 1'b0;
        for (int t = 1; t < 64; t++) begin
            step();
            exp = frame_exp(16'h0, 1'b0, (t >> 3) & 3, t & 7);
            n_checks++;
            if ({an, seg, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL reset_pending_lost t=%0d: got %b, expected %b", t, {an, seg, frame_done}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_atomic_update();
        test_lz_blank();
        test_enable_drop();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
